// File: rtl/pianotile_pkg.sv
// ---------------------------------------------------------------------------
// pianotile_pkg
//   Shared definitions for the piano-tile hit judge:
//     game_state_t : game FSM encoding (IDLE/PLAY/OVER), also the state output
//     ERR_W        : width of the faulty-row counter
//     POP_MAX_W    : widest vector the popcount helper accepts
//     popcount()   : number of set bits in a vector (zero-extend narrower inputs)
// ---------------------------------------------------------------------------
package pianotile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_OVER = 2'b10
    } game_state_t;

    localparam int ERR_W     = 8;
    localparam int POP_MAX_W = 32;

    function automatic logic [5:0] popcount(input logic [POP_MAX_W-1:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            n = n + 6'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/lane_hit_judge_btn_debounce.sv
// ---------------------------------------------------------------------------
// lane_btn_debounce
//   One lane of the button path: 2-flop synchroniser on the raw active-low
//   button, a debouncer that accepts a new level only after DEB_SAMPLES
//   consecutive sample points disagree with the current level, and a 1-clk
//   press pulse on every released->pressed change of the debounced level.
// Ports
//   clk       in  system clock
//   rst       in  asynchronous active-low reset
//   sample_en in  1-clk strobe from the shared sample divider
//   btn_n     in  raw asynchronous button, 0 = pressed
//   press     out 1-clk pulse on a debounced press
// ---------------------------------------------------------------------------
module lane_btn_debounce #(
    parameter int DEB_SAMPLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic btn_n,
    output logic press
);

    // The counter only has to reach DEB_SAMPLES-1: the DEB_SAMPLES-th
    // disagreeing sample flips the level directly.
    localparam int CNT_W = (DEB_SAMPLES > 1) ? $clog2(DEB_SAMPLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_SAMPLES - 1);

    // Synchroniser holds the pressed sense (inverted button), so a cleared
    // register means "released".
    logic             sync_meta_reg;
    logic             sync_reg;
    logic             level_reg;
    logic [CNT_W-1:0] deb_cnt_reg;
    logic             press_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_meta_reg <= 1'b0;
            sync_reg      <= 1'b0;
            level_reg     <= 1'b0;
            deb_cnt_reg   <= '0;
            press_reg     <= 1'b0;
        end else begin
            sync_meta_reg <= ~btn_n;
            sync_reg      <= sync_meta_reg;
            press_reg     <= 1'b0;
            if (sample_en) begin
                if (sync_reg != level_reg) begin
                    if (deb_cnt_reg == CNT_LAST) begin
                        level_reg   <= sync_reg;
                        deb_cnt_reg <= '0;
                        // Only the released->pressed direction produces a pulse.
                        press_reg   <= sync_reg;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end else begin
                    // Any agreeing sample breaks the run of disagreeing ones.
                    deb_cnt_reg <= '0;
                end
            end
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/lane_hit_judge.sv
// ---------------------------------------------------------------------------
// lane_hit_judge
//   N-lane hit judge for the piano-tile game. Debounced button presses are
//   latched per lane and judged against the current tile row on every
//   beat_tick while playing. Keeps score, combo and faulty-row count and runs
//   the IDLE/PLAY/OVER game state machine.
// Ports
//   clk         in   system clock
//   rst         in   asynchronous active-low reset
//   start       in   1-clk pulse: begin/restart a game (ignored in PLAY)
//   beat_tick   in   1-clk pulse: close the current judgement window
//   tile        in   expected notes of the current row (bit i = lane i)
//   btn_n       in   raw buttons, 0 = pressed
//   state       out  00 IDLE, 01 PLAY, 10 OVER
//   score       out  saturating accumulated hits
//   combo       out  saturating count of consecutive perfect non-empty rows
//   err_cnt     out  faulty rows this game
//   row_valid   out  1-clk pulse when row_hits/row_perfect are updated
//   row_hits    out  hit count of the last judged row
//   row_perfect out  last judged row was fully correct
// ---------------------------------------------------------------------------
module lane_hit_judge
    import pianotile_pkg::*;
#(
    parameter int LANES           = 3,
    parameter int SAMPLE_DIV_LOG2 = 8,
    parameter int DEB_SAMPLES     = 4,
    parameter int SCORE_W         = 16,
    parameter int COMBO_W         = 8,
    parameter int MAX_ERR         = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       beat_tick,
    input  logic [LANES-1:0]           tile,
    input  logic [LANES-1:0]           btn_n,
    output logic [1:0]                 state,
    output logic [SCORE_W-1:0]         score,
    output logic [COMBO_W-1:0]         combo,
    output logic [ERR_W-1:0]           err_cnt,
    output logic                       row_valid,
    output logic [$clog2(LANES+1)-1:0] row_hits,
    output logic                       row_perfect
);

    localparam int HIT_W = $clog2(LANES + 1);
    localparam logic [ERR_W-1:0] ERR_LIMIT = ERR_W'(MAX_ERR);

    // ------------------------------------------------------------------
    // Shared sample strobe for all lane debouncers
    // ------------------------------------------------------------------
    logic sample_en;

    generate
        if (SAMPLE_DIV_LOG2 == 0) begin : g_no_div
            assign sample_en = 1'b1;
        end else begin : g_div
            logic [SAMPLE_DIV_LOG2-1:0] div_cnt_reg;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    div_cnt_reg <= '0;
                end else begin
                    div_cnt_reg <= div_cnt_reg + 1'b1;
                end
            end
            assign sample_en = (div_cnt_reg == '0);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-lane button conditioning
    // ------------------------------------------------------------------
    logic [LANES-1:0] press;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            lane_btn_debounce #(
                .DEB_SAMPLES(DEB_SAMPLES)
            ) u_deb (
                .clk      (clk),
                .rst      (rst),
                .sample_en(sample_en),
                .btn_n    (btn_n[gi]),
                .press    (press[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and result registers
    // ------------------------------------------------------------------
    game_state_t        state_reg;
    logic [SCORE_W-1:0] score_reg;
    logic [COMBO_W-1:0] combo_reg;
    logic [ERR_W-1:0]   err_reg;
    logic               row_valid_reg;
    logic [HIT_W-1:0]   row_hits_reg;
    logic               row_perfect_reg;
    logic [LANES-1:0]   press_lat_reg;

    // ------------------------------------------------------------------
    // Press latches: cleared by the judging tick, but a press arriving in
    // that same cycle is ORed in after the clear so it lands in the next
    // window. Held clear whenever the game is not running.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            press_lat_reg <= '0;
        end else if (state_reg == ST_PLAY) begin
            press_lat_reg <= (beat_tick ? '0 : press_lat_reg) | press;
        end else begin
            press_lat_reg <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Judge datapath (combinational, consumed only on a PLAY tick)
    // ------------------------------------------------------------------
    logic [LANES-1:0]   hit_v;
    logic [LANES-1:0]   wrong_v;
    logic [LANES-1:0]   missed_v;
    logic               perfect;
    logic [HIT_W-1:0]   hit_cnt;
    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_judged;
    logic [COMBO_W-1:0] combo_judged;
    logic [ERR_W-1:0]   err_judged;
    logic               go_over;

    always_comb begin
        hit_v    = tile & press_lat_reg;
        wrong_v  = ~tile & press_lat_reg;
        missed_v = tile & ~press_lat_reg;
        perfect  = (wrong_v == '0) && (missed_v == '0);
        hit_cnt  = HIT_W'(popcount(POP_MAX_W'(hit_v)));

        // One extra bit catches the carry out for saturation.
        score_sum    = {1'b0, score_reg} + (SCORE_W + 1)'(hit_cnt);
        score_judged = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

        // An empty row answered with no press keeps the combo as is.
        combo_judged = '0;
        if (perfect && (tile != '0)) begin
            combo_judged = (combo_reg == '1) ? combo_reg : combo_reg + 1'b1;
        end else if (perfect) begin
            combo_judged = combo_reg;
        end

        err_judged = perfect ? err_reg : err_reg + 1'b1;
        go_over    = (err_judged == ERR_LIMIT);
    end

    // ------------------------------------------------------------------
    // Game FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= ST_IDLE;
            score_reg       <= '0;
            combo_reg       <= '0;
            err_reg         <= '0;
            row_valid_reg   <= 1'b0;
            row_hits_reg    <= '0;
            row_perfect_reg <= 1'b0;
        end else begin
            row_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE, ST_OVER: begin
                    // A tick arriving together with start is simply dropped.
                    if (start) begin
                        state_reg       <= ST_PLAY;
                        score_reg       <= '0;
                        combo_reg       <= '0;
                        err_reg         <= '0;
                        row_hits_reg    <= '0;
                        row_perfect_reg <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (beat_tick) begin
                        row_valid_reg   <= 1'b1;
                        row_hits_reg    <= hit_cnt;
                        row_perfect_reg <= perfect;
                        score_reg       <= score_judged;
                        combo_reg       <= combo_judged;
                        err_reg         <= err_judged;
                        if (go_over) begin
                            state_reg <= ST_OVER;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign state       = state_reg;
    assign score       = score_reg;
    assign combo       = combo_reg;
    assign err_cnt     = err_reg;
    assign row_valid   = row_valid_reg;
    assign row_hits    = row_hits_reg;
    assign row_perfect = row_perfect_reg;

endmodule

// File: tb/tb_lane_hit_judge.sv
module tb_lane_hit_judge;

    localparam int LANES   = 3;
    localparam int SDIV    = 2;
    localparam int DEB     = 2;
    localparam int SCORE_W = 2;
    localparam int COMBO_W = 2;
    localparam int MAX_ERR = 3;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;
    localparam int COMBO_MAX = (1 << COMBO_W) - 1;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               beat_tick = 1'b0;
    logic [LANES-1:0]   tile = '0;
    logic [LANES-1:0]   btn_n = '1;
    logic [1:0]         state;
    logic [SCORE_W-1:0] score;
    logic [COMBO_W-1:0] combo;
    logic [7:0]         err_cnt;
    logic               row_valid;
    logic [1:0]         row_hits;
    logic               row_perfect;

    lane_hit_judge #(
        .LANES(LANES), .SAMPLE_DIV_LOG2(SDIV), .DEB_SAMPLES(DEB),
        .SCORE_W(SCORE_W), .COMBO_W(COMBO_W), .MAX_ERR(MAX_ERR)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .beat_tick(beat_tick),
        .tile(tile), .btn_n(btn_n), .state(state), .score(score),
        .combo(combo), .err_cnt(err_cnt), .row_valid(row_valid),
        .row_hits(row_hits), .row_perfect(row_perfect)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hits;
        int perfect;
        int score;
        int combo;
        int err;
        int st;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Reference game model: 0 IDLE, 1 PLAY, 2 OVER
    int m_state = 0;
    int m_score = 0;
    int m_combo = 0;
    int m_err = 0;
    logic [LANES-1:0] held = '0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Judge one row against the game rules and queue the expected result.
    task automatic model_tick(input logic [LANES-1:0] t, input logic [LANES-1:0] lat);
        logic [LANES-1:0] wrong;
        logic [LANES-1:0] missed;
        int hits;
        int perf;
        exp_t e;
        if (m_state != 1) return;
        wrong  = ~t & lat;
        missed = t & ~lat;
        hits   = $countones(t & lat);
        perf   = (wrong == 0 && missed == 0) ? 1 : 0;
        m_score = (m_score + hits > SCORE_MAX) ? SCORE_MAX : m_score + hits;
        if (perf == 1 && t != 0) m_combo = (m_combo == COMBO_MAX) ? COMBO_MAX : m_combo + 1;
        else if (perf == 0) m_combo = 0;
        if (perf == 0) m_err++;
        if (m_err == MAX_ERR) m_state = 2;
        e.hits = hits; e.perfect = perf; e.score = m_score;
        e.combo = m_combo; e.err = m_err; e.st = m_state;
        exp_q.push_back(e);
    endtask

    // One judgement window: change button levels, optionally glitch a
    // released lane for 3 clk, let everything settle, then tick.
    task automatic window(input logic [LANES-1:0] press_new, input logic [LANES-1:0] release_m,
                          input logic [LANES-1:0] glitch_m, input logic [LANES-1:0] tile_v);
        logic [LANES-1:0] lat;
        logic [LANES-1:0] new_held;
        logic [LANES-1:0] gl;
        lat      = press_new & ~held;
        new_held = (held & ~release_m) | press_new;
        gl       = glitch_m & ~new_held & ~held;
        held     = new_held;
        btn_n    = ~held;
        repeat (6) @(negedge clk);
        btn_n = ~held & ~gl;
        repeat (3) @(negedge clk);
        btn_n = ~held;
        repeat (20) @(negedge clk);
        tile = tile_v;
        beat_tick = 1'b1;
        model_tick(tile_v, lat);
        @(negedge clk);
        beat_tick = 1'b0;
    endtask

    task automatic do_start(input logic with_tick, input logic [LANES-1:0] tile_v);
        start = 1'b1;
        beat_tick = with_tick;
        tile = tile_v;
        if (m_state != 1) begin
            m_state = 1; m_score = 0; m_combo = 0; m_err = 0;
        end
        @(negedge clk);
        start = 1'b0;
        beat_tick = 1'b0;
    endtask

    // Monitor: every row_valid pops one expected row result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && row_valid) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_row_valid actual=1 required=0");
                end else begin
                    e = exp_q.pop_front();
                    $display("row: hits=%0d perfect=%0d score=%0d combo=%0d err=%0d state=%0d",
                             row_hits, row_perfect, score, combo, err_cnt, state);
                    chk("row_hits", int'(row_hits), e.hits);
                    chk("row_perfect", int'(row_perfect), e.perfect);
                    chk("score", int'(score), e.score);
                    chk("combo", int'(combo), e.combo);
                    chk("err_cnt", int'(err_cnt), e.err);
                    chk("state", int'(state), e.st);
                end
            end
        end
    end

    initial begin
        logic [LANES-1:0] t;
        logic [LANES-1:0] p;
        logic [LANES-1:0] r;
        logic [LANES-1:0] g;
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_combo", int'(combo), 0);
        chk("reset_err", int'(err_cnt), 0);
        chk("reset_row_valid", int'(row_valid), 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Tick in IDLE is ignored
        window(3'b000, 3'b000, 3'b000, 3'b011);
        chk("idle_state", int'(state), 0);

        do_start(1'b0, 3'b000);
        chk("start_state", int'(state), 1);

        // Two lanes hit exactly
        window(3'b101, 3'b000, 3'b000, 3'b101);
        // Glitch on lane 1 does not latch
        window(3'b000, 3'b101, 3'b010, 3'b010);
        // Held button: hit on first row, missed on second
        window(3'b100, 3'b000, 3'b000, 3'b100);
        window(3'b000, 3'b000, 3'b000, 3'b100);
        // Wrong lane -> third fault ends the game
        window(3'b000, 3'b100, 3'b000, 3'b000);
        window(3'b100, 3'b000, 3'b000, 3'b001);
        chk("over_state", int'(state), 2);
        // Tick in OVER is ignored
        window(3'b001, 3'b100, 3'b000, 3'b001);
        chk("over_hold_err", int'(err_cnt), MAX_ERR);

        // start + tick in OVER: start wins, counters cleared
        do_start(1'b1, 3'b111);
        chk("restart_state", int'(state), 1);
        chk("restart_score", int'(score), 0);
        chk("restart_err", int'(err_cnt), 0);
        chk("restart_combo", int'(combo), 0);

        // Saturation of score and combo
        for (int i = 0; i < 4; i++) begin
            window(3'b111, 3'b000, 3'b000, 3'b111);
            window(3'b000, 3'b111, 3'b000, 3'b000);
        end

        // Randomised games
        for (int game = 0; game < 4; game++) begin
            n = 0;
            while (m_state == 1 && n < 12) begin
                t = LANES'($urandom_range(0, 7));
                p = ($urandom_range(0, 3) == 0) ? LANES'($urandom_range(0, 7)) : t;
                r = LANES'($urandom_range(0, 7));
                g = LANES'($urandom_range(0, 7));
                window(p, r, g, t);
                n++;
            end
            do_start(1'(($urandom_range(0, 1))), LANES'($urandom_range(0, 7)));
            chk("game_start_state", int'(state), 1);
        end

        // Async reset mid-PLAY
        window(3'b000, 3'b111, 3'b000, 3'b000);
        window(3'b011, 3'b000, 3'b000, 3'b011);
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", int'(state), 0);
        chk("arst_score", int'(score), 0);
        chk("arst_combo", int'(combo), 0);
        chk("arst_err", int'(err_cnt), 0);
        chk("arst_row_hits", int'(row_hits), 0);
        m_state = 0; m_score = 0; m_combo = 0; m_err = 0;
        btn_n = '1;
        held = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_reset_state", int'(state), 0);
        chk("pending_rows", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
